multicycle_controller: RTL and testbench

//  Sequencing FSM for the multicycle RV32I datapath: one shared ALU, one unified instr/data memory port.

---
 rtl/mc_pkg.sv | 71 +++++++
 rtl/mc_output_map.sv | 99 +++++++++
 rtl/multicycle_controller.sv | 96 +++++++++
 tb/tb_multicycle_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mc_pkg
// Purpose  : Shared state, opcode and control-select encodings for the
//            multicycle RV32I controller and its datapath muxes.
// Revision : 1.0
// ============================================================================
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_UIMM     = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_JALRWB   = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [1:0] c_a_pc      = 2'b00;
    localparam logic [1:0] c_a_oldpc   = 2'b01;
    localparam logic [1:0] c_a_rs1     = 2'b10;
    localparam logic [1:0] c_a_zero    = 2'b11;

    localparam logic [1:0] c_b_rs2     = 2'b00;
    localparam logic [1:0] c_b_imm     = 2'b01;
    localparam logic [1:0] c_b_four    = 2'b10;

    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_funct = 2'b10;

    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_rdata  = 2'b01;
    localparam logic [1:0] c_res_alures = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       branch;
        logic       illegal_op;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_output_map.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mc_output_map
// Purpose  : Combinational state -> Moore control word.
// Revision : 1.0
// ============================================================================
module mc_output_map
    import mc_pkg::*;
(
    input  state_t state,
    input  logic   uimm_is_lui,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = c_a_pc;
                ctrl.alu_src_b  = c_b_four;
                ctrl.alu_op     = c_alu_add;
                ctrl.result_src = c_res_alures;
            end
            S_DECODE: begin
                ctrl.alu_src_a = c_a_oldpc;
                ctrl.alu_src_b = c_b_imm;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = c_a_rs1;
                ctrl.alu_src_b = c_b_imm;
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = c_res_rdata;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = c_a_rs1;
                ctrl.alu_src_b = c_b_rs2;
                ctrl.alu_op    = c_alu_funct;
            end
            S_EXECI: begin
                ctrl.alu_src_a = c_a_rs1;
                ctrl.alu_src_b = c_b_imm;
                ctrl.alu_op    = c_alu_funct;
            end
            S_UIMM: begin
                ctrl.alu_src_a = uimm_is_lui ? c_a_zero : c_a_oldpc;
                ctrl.alu_src_b = c_b_imm;
            end
            S_ALUWB: begin
                ctrl.result_src = c_res_aluout;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = c_a_rs1;
                ctrl.alu_src_b  = c_b_rs2;
                ctrl.alu_op     = c_alu_sub;
                ctrl.branch     = 1'b1;
                ctrl.result_src = c_res_aluout;
            end
            S_JAL: begin
                // PC takes the target computed in DECODE while ALU forms OldPC+4
                ctrl.alu_src_a  = c_a_oldpc;
                ctrl.alu_src_b  = c_b_four;
                ctrl.result_src = c_res_aluout;
                ctrl.pc_write   = 1'b1;
            end
            S_JALR: begin
                ctrl.alu_src_a  = c_a_rs1;
                ctrl.alu_src_b  = c_b_imm;
                ctrl.result_src = c_res_alures;
                ctrl.pc_write   = 1'b1;
            end
            S_JALRWB: begin
                ctrl.alu_src_a  = c_a_oldpc;
                ctrl.alu_src_b  = c_b_four;
                ctrl.result_src = c_res_alures;
                ctrl.reg_write  = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Sequencing FSM for the multicycle RV32I datapath.
// Revision : 1.0
// ============================================================================
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int STATE_W         = 4,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               branch_taken,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         result_src,
    output logic               branch,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
);

    state_t r_state;
    logic   r_op5;      // op[5] captured in DECODE: store vs load, LUI vs AUIPC
    ctrl_t  w_ctrl;
    logic   w_live;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_op5   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_op5 <= op[5];
                    case (op)
                        c_op_load, c_op_store: r_state <= S_MEMADR;
                        c_op_rtype:            r_state <= S_EXECR;
                        c_op_itype:            r_state <= S_EXECI;
                        c_op_branch:           r_state <= S_BRANCH;
                        c_op_jal:              r_state <= S_JAL;
                        c_op_jalr:             r_state <= S_JALR;
                        c_op_lui, c_op_auipc:  r_state <= S_UIMM;
                        default:               r_state <= HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
                    endcase
                end
                S_MEMADR:   r_state <= r_op5 ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXECR, S_EXECI, S_UIMM, S_JAL: r_state <= S_ALUWB;
                S_JALR:     r_state <= S_JALRWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_JALRWB: r_state <= S_FETCH;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    mc_output_map u_output_map (
        .state       (r_state),
        .uimm_is_lui (r_op5),
        .ctrl        (w_ctrl)
    );

    // Reset forces every strobe and select low, including the FETCH request
    assign w_live     = ~reset;
    assign mem_req    = w_live & w_ctrl.mem_req;
    assign mem_write  = w_live & w_ctrl.mem_write;
    assign adr_src    = w_live & w_ctrl.adr_src;
    assign ir_write   = w_live & (r_state == S_FETCH) & mem_ready;
    assign pc_write   = w_live & (w_ctrl.pc_write
                                  | ((r_state == S_FETCH)  & mem_ready)
                                  | ((r_state == S_BRANCH) & branch_taken));
    assign reg_write  = w_live & w_ctrl.reg_write;
    assign alu_src_a  = w_live ? w_ctrl.alu_src_a  : 2'b00;
    assign alu_src_b  = w_live ? w_ctrl.alu_src_b  : 2'b00;
    assign alu_op     = w_live ? w_ctrl.alu_op     : 2'b00;
    assign result_src = w_live ? w_ctrl.result_src : 2'b00;
    assign branch     = w_live & w_ctrl.branch;
    assign illegal_op = w_live & w_ctrl.illegal_op;
    assign state_o    = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed, table-driven check of the multicycle controller.
// Revision : 1.0
// ============================================================================
module tb_multicycle_controller;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       branch, illegal_op;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.STATE_W(4), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .branch(branch),
        .illegal_op(illegal_op), .state_o(state_o)
    );

    logic [15:0] act_w;
    assign act_w = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                    alu_src_a, alu_src_b, alu_op, result_src, branch, illegal_op};

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic        bt;
        state_t      st;
        logic [15:0] w;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] mk(input logic mreq, mw, adr, ir, pc, rw,
                                       input logic [1:0] a, b, aop, rs,
                                       input logic br, ill);
        return {mreq, mw, adr, ir, pc, rw, a, b, aop, rs, br, ill};
    endfunction

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input logic [6:0] o, input logic r, input logic b,
                        input state_t s, input logic [15:0] w, input string nm);
        op = o; mem_ready = r; branch_taken = b;
        #1;
        check({nm, " state"}, {12'b0, state_o}, {12'b0, 4'(s)});
        check({nm, " ctrl"}, act_w, w);
        @(negedge clk);
    endtask

    task automatic add(input logic [6:0] o, input logic r, input logic b,
                       input state_t s, input logic [15:0] w);
        vec_t v;
        v.op = o; v.rdy = r; v.bt = b; v.st = s; v.w = w;
        vecs.push_back(v);
    endtask

    localparam logic [6:0] X = 7'h7F;

    logic [15:0] w_zero, w_f1, w_f0, w_dec, w_madr, w_mrd, w_mwb, w_mwr, w_exr, w_exi;
    logic [15:0] w_lui, w_auipc, w_aluwb, w_brt, w_brn, w_jal, w_jalr, w_jalrwb, w_trap;

    initial begin
        w_zero   = 16'h0000;
        w_f1     = mk(1,0,0,1,1,0, 2'b00,2'b10,2'b00,2'b10, 0,0);
        w_f0     = mk(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0);
        w_dec    = mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0);
        w_madr   = mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0);
        w_mrd    = mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
        w_mwb    = mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 0,0);
        w_mwr    = mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
        w_exr    = mk(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0);
        w_exi    = mk(0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 0,0);
        w_lui    = mk(0,0,0,0,0,0, 2'b11,2'b01,2'b00,2'b00, 0,0);
        w_auipc  = mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0);
        w_aluwb  = mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0);
        w_brt    = mk(0,0,0,0,1,0, 2'b10,2'b00,2'b01,2'b00, 1,0);
        w_brn    = mk(0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 1,0);
        w_jal    = mk(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 0,0);
        w_jalr   = mk(0,0,0,0,1,0, 2'b10,2'b01,2'b00,2'b10, 0,0);
        w_jalrwb = mk(0,0,0,0,0,1, 2'b01,2'b10,2'b00,2'b10, 0,0);
        w_trap   = mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1);

        // add: op garbage outside DECODE must not matter
        add(X, 1,1, S_FETCH, w_f1); add(7'b0110011, 1,1, S_DECODE, w_dec);
        add(X, 1,1, S_EXECR, w_exr); add(X, 1,1, S_ALUWB, w_aluwb);
        // lw with one fetch wait and two read waits; store opcode in IR during MEMADR
        add(X, 0,1, S_FETCH, w_f0); add(X, 1,1, S_FETCH, w_f1);
        add(7'b0000011, 1,1, S_DECODE, w_dec); add(7'b0100011, 1,1, S_MEMADR, w_madr);
        add(X, 0,1, S_MEMREAD, w_mrd); add(X, 0,1, S_MEMREAD, w_mrd);
        add(X, 1,1, S_MEMREAD, w_mrd); add(X, 1,1, S_MEMWB, w_mwb);
        // beq taken, then not taken
        add(X, 1,1, S_FETCH, w_f1); add(7'b1100011, 1,1, S_DECODE, w_dec);
        add(X, 1,1, S_BRANCH, w_brt);
        add(X, 1,1, S_FETCH, w_f1); add(7'b1100011, 1,1, S_DECODE, w_dec);
        add(X, 1,0, S_BRANCH, w_brn);
        // jal, jalr
        add(X, 1,1, S_FETCH, w_f1); add(7'b1101111, 1,1, S_DECODE, w_dec);
        add(X, 1,1, S_JAL, w_jal); add(X, 1,1, S_ALUWB, w_aluwb);
        add(X, 1,1, S_FETCH, w_f1); add(7'b1100111, 1,1, S_DECODE, w_dec);
        add(X, 1,1, S_JALR, w_jalr); add(X, 1,1, S_JALRWB, w_jalrwb);
        // sw zero-wait, load opcode in IR during MEMADR
        add(X, 1,1, S_FETCH, w_f1); add(7'b0100011, 1,1, S_DECODE, w_dec);
        add(7'b0000011, 1,1, S_MEMADR, w_madr); add(X, 1,1, S_MEMWRITE, w_mwr);
        // addi, lui, auipc (IR swapped after DECODE)
        add(X, 1,1, S_FETCH, w_f1); add(7'b0010011, 1,1, S_DECODE, w_dec);
        add(X, 1,1, S_EXECI, w_exi); add(X, 1,1, S_ALUWB, w_aluwb);
        add(X, 1,1, S_FETCH, w_f1); add(7'b0110111, 1,1, S_DECODE, w_dec);
        add(7'b0010111, 1,1, S_UIMM, w_lui); add(X, 1,1, S_ALUWB, w_aluwb);
        add(X, 1,1, S_FETCH, w_f1); add(7'b0010111, 1,1, S_DECODE, w_dec);
        add(7'b0110111, 1,1, S_UIMM, w_auipc); add(X, 1,1, S_ALUWB, w_aluwb);
        // illegal opcode -> sticky trap
        add(X, 1,1, S_FETCH, w_f1); add(7'h7F, 1,1, S_DECODE, w_dec);
        for (int i = 0; i < 20; i++) add(7'b0110011, 1,1, S_TRAP, w_trap);

        reset = 1'b1; op = 7'h00; mem_ready = 1'b0; branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        mem_ready = 1'b1; branch_taken = 1'b1;
        #1;
        check("reset state", {12'b0, state_o}, {12'b0, 4'(S_FETCH)});
        check("reset ctrl", act_w, w_zero);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].op, vecs[i].rdy, vecs[i].bt, vecs[i].st, vecs[i].w,
                 $sformatf("vec%0d", i));

        // leave TRAP only by reset
        reset = 1'b1;
        #1;
        check("trap reset state", {12'b0, state_o}, {12'b0, 4'(S_FETCH)});
        check("trap reset ctrl", act_w, w_zero);
        @(negedge clk);
        reset = 1'b0;
        step(X, 1,1, S_FETCH, w_f1, "post-trap fetch");

        // async reset while a store waits
        step(7'b0100011, 1,1, S_DECODE, w_dec, "st decode");
        step(X, 1,1, S_MEMADR, w_madr, "st memadr");
        step(X, 0,1, S_MEMWRITE, w_mwr, "st wait1");
        op = X; mem_ready = 1'b0;
        #1;
        check("st wait2 ctrl", act_w, w_mwr);
        #2 reset = 1'b1;
        #1;
        check("async reset ctrl", act_w, w_zero);
        check("async reset state", {12'b0, state_o}, {12'b0, 4'(S_FETCH)});
        @(negedge clk);
        reset = 1'b0;
        step(X, 0,1, S_FETCH, w_f0, "resume fetch wait");
        step(X, 1,1, S_FETCH, w_f1, "resume fetch");
        step(7'b0110011, 1,1, S_DECODE, w_dec, "resume decode");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
